io_rr_arbiter: RTL

Round-robin arbiter that shares the urisc I/O memory port between `N_REQ` I/O devices (VGA reader, PS/2 writer, future peripherals). Each device raises a request carrying address, direction and write data. The arbiter grants one device at a time, runs a single strobe/ack transaction on the shared port, returns read data and a completion pulse, then rotates priority. A timeout counter stops a missing acknowledge from hanging the bus.

---
 rtl/io_rr_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/io_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : io_rr_arbiter
//  Description : Round-robin arbiter sharing the urisc I/O memory port between
//                N_REQ devices. One strobe/ack transaction at a time, with an
//                ack timeout so a silent memory cannot hang the bus.
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous active-low reset
//                req        - per-device request level
//                req_dir    - per-device direction (1 = write, 0 = read)
//                req_addr   - packed per-device addresses
//                req_wdata  - packed per-device write data
//                gnt        - one-hot grant, high for the whole transaction
//                done       - one-cycle completion pulse to the granted device
//                err        - one-cycle timeout flag, coincident with done
//                rdata      - last read data, held until the next read
//                mem_*      - shared memory port (strobe/dir/addr/wdata out,
//                             rdata/ack in)
//  Revision    : 1.0 - initial release
// ============================================================================
module io_rr_arbiter #(
    parameter int N_REQ     = 2,
    parameter int WORD_SIZE = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           req_dir,
    input  logic [N_REQ*WORD_SIZE-1:0] req_addr,
    input  logic [N_REQ*WORD_SIZE-1:0] req_wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic                       err,
    output logic [WORD_SIZE-1:0]       rdata,
    output logic                       mem_strobe,
    output logic                       mem_dir,
    output logic [WORD_SIZE-1:0]       mem_addr,
    output logic [WORD_SIZE-1:0]       mem_wdata,
    input  logic [WORD_SIZE-1:0]       mem_rdata,
    input  logic                       mem_ack
);

    localparam int          c_IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int          c_CNT_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned c_NREQ_U = N_REQ;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state,     w_state;
    logic [c_IDX_W-1:0]     r_ptr,       w_ptr;
    logic [c_IDX_W-1:0]     r_idx,       w_idx;
    logic [c_CNT_W-1:0]     r_cnt,       w_cnt;
    logic                   r_timedOut,  w_timedOut;
    logic [N_REQ-1:0]       r_gnt,       w_gnt;
    logic [N_REQ-1:0]       r_done,      w_done;
    logic                   r_err,       w_err;
    logic [WORD_SIZE-1:0]   r_rdata,     w_rdata;
    logic                   r_memStrobe, w_memStrobe;
    logic                   r_memDir,    w_memDir;
    logic [WORD_SIZE-1:0]   r_memAddr,   w_memAddr;
    logic [WORD_SIZE-1:0]   r_memWdata,  w_memWdata;
    logic [c_CNT_W-1:0]     w_cntInc;
    logic                   w_found;
    logic [c_IDX_W-1:0]     w_sel;

    // (base + off) mod N_REQ; both operands are already below N_REQ, so a
    // single conditional subtraction is enough.
    function automatic logic [c_IDX_W-1:0] wrapIdx(input int unsigned base,
                                                   input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= c_NREQ_U) begin
            s = s - c_NREQ_U;
        end
        return s[c_IDX_W-1:0];
    endfunction

    // Round-robin pick: first set request scanning upward from r_ptr with
    // wrap-around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[wrapIdx(32'(r_ptr), 32'(i))]) begin
                w_found = 1'b1;
                w_sel   = wrapIdx(32'(r_ptr), 32'(i));
            end
        end
    end

    always_comb begin
        w_state     = r_state;
        w_ptr       = r_ptr;
        w_idx       = r_idx;
        w_cnt       = r_cnt;
        w_timedOut  = r_timedOut;
        w_gnt       = r_gnt;
        w_done      = '0;
        w_err       = 1'b0;
        w_rdata     = r_rdata;
        w_memStrobe = r_memStrobe;
        w_memDir    = r_memDir;
        w_memAddr   = r_memAddr;
        w_memWdata  = r_memWdata;
        w_cntInc    = r_cnt + c_CNT_W'(1);

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_idx        = w_sel;
                    w_memDir     = req_dir[w_sel];
                    w_memAddr    = req_addr[w_sel*WORD_SIZE +: WORD_SIZE];
                    w_memWdata   = req_wdata[w_sel*WORD_SIZE +: WORD_SIZE];
                    w_gnt        = '0;
                    w_gnt[w_sel] = 1'b1;
                    w_memStrobe  = 1'b1;
                    w_cnt        = '0;
                    w_timedOut   = 1'b0;
                    w_state      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_cnt = w_cntInc;
                // Ack is tested first so an ack in the final allowed cycle
                // still completes cleanly instead of reporting a timeout.
                if (mem_ack) begin
                    w_memStrobe = 1'b0;
                    if (!r_memDir) begin
                        w_rdata = mem_rdata;
                    end
                    w_state = ST_DONE;
                end else if (w_cntInc == c_CNT_W'(TIMEOUT)) begin
                    w_memStrobe = 1'b0;
                    w_timedOut  = 1'b1;
                    w_state     = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done  = r_gnt;
                w_err   = r_timedOut;
                w_gnt   = '0;
                w_ptr   = (r_idx == c_IDX_W'(N_REQ - 1)) ? '0 : r_idx + c_IDX_W'(1);
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_timedOut  <= 1'b0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_memStrobe <= 1'b0;
            r_memDir    <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
        end else begin
            r_state     <= w_state;
            r_ptr       <= w_ptr;
            r_idx       <= w_idx;
            r_cnt       <= w_cnt;
            r_timedOut  <= w_timedOut;
            r_gnt       <= w_gnt;
            r_done      <= w_done;
            r_err       <= w_err;
            r_rdata     <= w_rdata;
            r_memStrobe <= w_memStrobe;
            r_memDir    <= w_memDir;
            r_memAddr   <= w_memAddr;
            r_memWdata  <= w_memWdata;
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign err        = r_err;
    assign rdata      = r_rdata;
    assign mem_strobe = r_memStrobe;
    assign mem_dir    = r_memDir;
    assign mem_addr   = r_memAddr;
    assign mem_wdata  = r_memWdata;

endmodule
`default_nettype wire
